// File: rtl/rv32_pkg.sv
// Shared RV32I definitions for the execute stage: opcodes, funct3 encodings and the word type.
package rv32_pkg;

    typedef logic [31:0] word_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_RIMM   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/rv32_imm_gen.sv
// Immediate decoder: extracts and sign-extends the immediate field selected by the opcode.
module rv32_imm_gen
    import rv32_pkg::*;
(
    input  logic [31:0] instr,
    output logic [31:0] imm
);

    always_comb begin
        imm = '0;
        case (instr[6:0])
            OP_LOAD, OP_RIMM, OP_JALR:
                imm = {{20{instr[31]}}, instr[31:20]};
            OP_STORE:
                imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OP_BRANCH:
                imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                imm = {instr[31:12], 12'b0};
            OP_JAL:
                imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            default:
                imm = '0;
        endcase
    end

endmodule

// File: rtl/rv32_exec_unit.sv
// RV32I execute stage: immediate decode, integer ALU, branch condition and optional output register.
module rv32_exec_unit
    import rv32_pkg::*;
#(
    parameter bit REG_OUT = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        in_valid,
    input  logic [31:0] instr,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic [31:0] imm,
    output logic [31:0] result,
    output logic        take_b,
    output logic        out_valid,
    output logic [31:0] imm_q,
    output logic [31:0] result_q,
    output logic        take_b_q
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [4:0] shamt;
    logic       is_alu_op;

    assign opcode    = instr[6:0];
    assign funct3    = instr[14:12];
    assign shamt     = in_b[4:0];
    assign is_alu_op = (opcode == OP_R) || (opcode == OP_RIMM);

    rv32_imm_gen u_imm_gen (
        .instr (instr),
        .imm   (imm)
    );

    // Non-ALU opcodes reuse the adder for PC+4, PC+imm and load/store addresses.
    always_comb begin
        result = in_a + in_b;
        if (is_alu_op) begin
            case (funct3)
                F3_ADD:  result = (opcode == OP_R && instr[30]) ? (in_a - in_b) : (in_a + in_b);
                F3_SLL:  result = in_a << shamt;
                F3_SLT:  result = {31'b0, $signed(in_a) < $signed(in_b)};
                F3_SLTU: result = {31'b0, in_a < in_b};
                F3_XOR:  result = in_a ^ in_b;
                F3_SR:   result = instr[30] ? word_t'($signed(in_a) >>> shamt) : (in_a >> shamt);
                F3_OR:   result = in_a | in_b;
                F3_AND:  result = in_a & in_b;
                default: result = in_a + in_b;
            endcase
        end
    end

    always_comb begin
        take_b = 1'b0;
        if (opcode == OP_BRANCH) begin
            case (funct3)
                F3_BEQ:  take_b = (in_a == in_b);
                F3_BNE:  take_b = (in_a != in_b);
                F3_BLT:  take_b = ($signed(in_a) < $signed(in_b));
                F3_BGE:  take_b = ($signed(in_a) >= $signed(in_b));
                F3_BLTU: take_b = (in_a < in_b);
                F3_BGEU: take_b = (in_a >= in_b);
                default: take_b = 1'b0;
            endcase
        end
    end

    generate
        if (REG_OUT) begin : g_reg_out
            // Data only updates on valid cycles so downstream can sample the last result at leisure.
            always_ff @(posedge clk) begin
                if (!resetn) begin
                    out_valid <= 1'b0;
                    imm_q     <= '0;
                    result_q  <= '0;
                    take_b_q  <= 1'b0;
                end else begin
                    out_valid <= in_valid;
                    if (in_valid) begin
                        imm_q    <= imm;
                        result_q <= result;
                        take_b_q <= take_b;
                    end
                end
            end
        end else begin : g_comb_out
            assign out_valid = in_valid;
            assign imm_q     = imm;
            assign result_q  = result;
            assign take_b_q  = take_b;
        end
    endgenerate

endmodule

// File: tb/tb_rv32_exec_unit.sv
// Self-checking bench for rv32_exec_unit: directed test-plan vectors plus randomized instructions vs a spec model.
module tb_rv32_exec_unit;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] instr = 32'h0;
    logic [31:0] in_a = 32'h0;
    logic [31:0] in_b = 32'h0;
    logic [31:0] imm;
    logic [31:0] result;
    logic        take_b;
    logic        out_valid;
    logic [31:0] imm_q;
    logic [31:0] result_q;
    logic        take_b_q;

    int checks = 0;
    int failures = 0;

    // Expected registered outputs, updated at each clock edge from the model.
    logic [31:0] exp_imm_q = 32'h0;
    logic [31:0] exp_result_q = 32'h0;
    logic        exp_take_q = 1'b0;

    rv32_exec_unit #(.REG_OUT(1'b1)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .instr     (instr),
        .in_a      (in_a),
        .in_b      (in_b),
        .imm       (imm),
        .result    (result),
        .take_b    (take_b),
        .out_valid (out_valid),
        .imm_q     (imm_q),
        .result_q  (result_q),
        .take_b_q  (take_b_q)
    );

    always #5 clk = ~clk;

    // Reference model: immediate built from signed arithmetic on the instruction word.
    function automatic logic [31:0] model_imm(logic [31:0] i);
        int s;
        int v;
        s = i;
        case (i[6:0])
            7'h03, 7'h13, 7'h67: v = s >>> 20;
            7'h23: v = ((s >>> 25) * 32) + int'(i[11:7]);
            7'h63: v = ((s >>> 31) * 4096) + int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
            7'h37, 7'h17: v = s - int'(i[11:0]);
            7'h6F: v = ((s >>> 31) * 1048576) + int'(i[19:12]) * 4096 + int'(i[20]) * 2048 + int'(i[30:21]) * 2;
            default: v = 0;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] model_result(logic [31:0] i, logic [31:0] a, logic [31:0] b);
        longint ua;
        longint ub;
        int sa;
        int sb;
        int sh;
        longint mask;
        ua = a;
        ub = b;
        sa = a;
        sb = b;
        sh = int'(b) & 31;
        mask = 64'hFFFF_FFFF;
        if (i[6:0] != 7'h33 && i[6:0] != 7'h13) return 32'((ua + ub) & mask);
        case (i[14:12])
            3'd0: return (i[6:0] == 7'h33 && i[30]) ? 32'((ua - ub) & mask) : 32'((ua + ub) & mask);
            3'd1: return 32'((ua * (64'd1 << sh)) & mask);
            3'd2: return (sa < sb) ? 32'd1 : 32'd0;
            3'd3: return (ua < ub) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: return i[30] ? 32'(sa >>> sh) : 32'(ua / (64'd1 << sh));
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic logic model_take(logic [31:0] i, logic [31:0] a, logic [31:0] b);
        longint ua;
        longint ub;
        int sa;
        int sb;
        ua = a;
        ub = b;
        sa = a;
        sb = b;
        if (i[6:0] != 7'h63) return 1'b0;
        case (i[14:12])
            3'd0: return ua == ub;
            3'd1: return ua != ub;
            3'd4: return sa < sb;
            3'd5: return sa >= sb;
            3'd6: return ua < ub;
            3'd7: return ua >= ub;
            default: return 1'b0;
        endcase
    endfunction

    // Drive a new operation at the falling edge, then let combinational outputs settle.
    task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        in_valid = v;
        instr = i;
        in_a = a;
        in_b = b;
        #1;
    endtask

    // Advance one rising edge, updating the expected registered state from the model.
    task automatic clock_edge();
        @(posedge clk);
        if (!resetn) begin
            exp_imm_q = 32'h0;
            exp_result_q = 32'h0;
            exp_take_q = 1'b0;
        end else if (in_valid) begin
            exp_imm_q = model_imm(instr);
            exp_result_q = model_result(instr, in_a, in_b);
            exp_take_q = model_take(instr, in_a, in_b);
        end
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        drive(1'b1, 32'h00000033, 32'd9, 32'd9);
        clock_edge();
        clock_edge();
        checks++;
        if (out_valid !== 1'b0 || imm_q !== 32'h0 || result_q !== 32'h0 || take_b_q !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_q: got v=%0b imm=%h res=%h tb=%0b, want all 0",
                     out_valid, imm_q, result_q, take_b_q);
        end
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        resetn = 1'b1;
        clock_edge();
    endtask

    typedef struct {
        logic [31:0] i;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] e_imm;
        logic [31:0] e_res;
        logic        e_take;
    } vec_t;

    task automatic test_directed();
        vec_t vecs[$];
        vecs.push_back('{32'h00000033, 32'd7, 32'd5, 32'h0, 32'd12, 1'b0});
        vecs.push_back('{32'h40000033, 32'd5, 32'd7, 32'h0, 32'hFFFFFFFE, 1'b0});
        vecs.push_back('{32'h40000013, 32'd5, 32'd7, 32'h400, 32'd12, 1'b0});
        vecs.push_back('{32'h40005033, 32'h80000000, 32'h21, 32'h0, 32'hC0000000, 1'b0});
        vecs.push_back('{32'h00005033, 32'h80000000, 32'h21, 32'h0, 32'h40000000, 1'b0});
        vecs.push_back('{32'h00002033, 32'hFFFFFFFF, 32'd1, 32'h0, 32'd1, 1'b0});
        vecs.push_back('{32'h00003033, 32'hFFFFFFFF, 32'd1, 32'h0, 32'd0, 1'b0});
        vecs.push_back('{32'h00004063, 32'hFFFFFFFF, 32'd1, 32'h0, 32'h0, 1'b1});
        vecs.push_back('{32'h00006063, 32'hFFFFFFFF, 32'd1, 32'h0, 32'h0, 1'b0});
        vecs.push_back('{32'h00007063, 32'hFFFFFFFF, 32'd1, 32'h0, 32'h0, 1'b1});
        vecs.push_back('{32'h00000063, 32'd3, 32'd3, 32'h0, 32'd6, 1'b1});
        vecs.push_back('{32'h00002063, 32'hFFFFFFFF, 32'd1, 32'h0, 32'h0, 1'b0});
        vecs.push_back('{32'h00004033, 32'hFFFFFFFF, 32'd1, 32'h0, 32'hFFFFFFFE, 1'b0});
        vecs.push_back('{32'hFFF00093, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0});
        vecs.push_back('{32'h123450B7, 32'h0, 32'h12345000, 32'h12345000, 32'h12345000, 1'b0});
        vecs.push_back('{32'hFFDFF0EF, 32'h100, 32'd4, 32'hFFFFFFFC, 32'h104, 1'b0});
        vecs.push_back('{32'h00002423, 32'h1000, 32'd8, 32'd8, 32'h1008, 1'b0});
        vecs.push_back('{32'h00000097, 32'h100, 32'h1000, 32'h0, 32'h1100, 1'b0});
        foreach (vecs[k]) begin
            drive(1'b0, vecs[k].i, vecs[k].a, vecs[k].b);
            checks++;
            if (imm !== vecs[k].e_imm || result !== vecs[k].e_res || take_b !== vecs[k].e_take) begin
                failures++;
                $display("[TB] FAIL directed_%0d instr=%h: got imm=%h res=%h tb=%0b, want imm=%h res=%h tb=%0b",
                         k, vecs[k].i, imm, result, take_b, vecs[k].e_imm, vecs[k].e_res, vecs[k].e_take);
            end
        end
    endtask

    task automatic test_register_stage();
        drive(1'b1, 32'h00000033, 32'd2, 32'd3);
        clock_edge();
        checks++;
        if (out_valid !== 1'b1 || result_q !== 32'd5) begin
            failures++;
            $display("[TB] FAIL reg_capture: got v=%0b res_q=%h, want v=1 res_q=5", out_valid, result_q);
        end
        drive(1'b0, 32'h00000033, 32'd100, 32'd200);
        clock_edge();
        checks++;
        if (out_valid !== 1'b0 || result_q !== 32'd5) begin
            failures++;
            $display("[TB] FAIL reg_hold: got v=%0b res_q=%h, want v=0 res_q=5", out_valid, result_q);
        end
        drive(1'b1, 32'h00000033, 32'd40, 32'd2);
        resetn = 1'b0;
        clock_edge();
        checks++;
        if (out_valid !== 1'b0 || result_q !== 32'h0) begin
            failures++;
            $display("[TB] FAIL reg_reset_clear: got v=%0b res_q=%h, want v=0 res_q=0", out_valid, result_q);
        end
        drive(1'b1, 32'h00000033, 32'd40, 32'd2);
        resetn = 1'b1;
        clock_edge();
        checks++;
        if (out_valid !== 1'b1 || result_q !== 32'd42) begin
            failures++;
            $display("[TB] FAIL reg_post_reset: got v=%0b res_q=%h, want v=1 res_q=2a", out_valid, result_q);
        end
    endtask

    // Random instructions with random valid, checking both combinational and registered outputs.
    task automatic test_random(input int n);
        logic [6:0] ops[11];
        logic [31:0] i;
        logic [31:0] a;
        logic [31:0] b;
        logic v;
        logic exp_v;
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h73, 7'h7F};
        for (int k = 0; k < n; k++) begin
            i = $urandom;
            i[6:0] = ops[$urandom_range(0, 10)];
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : 32'($urandom);
            v = ($urandom_range(0, 3) != 0);
            drive(v, i, a, b);
            checks++;
            if (imm !== model_imm(i) || result !== model_result(i, a, b) || take_b !== model_take(i, a, b)) begin
                failures++;
                $display("[TB] FAIL random_comb instr=%h a=%h b=%h: got imm=%h res=%h tb=%0b, want imm=%h res=%h tb=%0b",
                         i, a, b, imm, result, take_b, model_imm(i), model_result(i, a, b), model_take(i, a, b));
            end
            exp_v = v;
            clock_edge();
            checks++;
            if (out_valid !== exp_v || imm_q !== exp_imm_q || result_q !== exp_result_q || take_b_q !== exp_take_q) begin
                failures++;
                $display("[TB] FAIL random_q instr=%h: got v=%0b imm=%h res=%h tb=%0b, want v=%0b imm=%h res=%h tb=%0b",
                         i, out_valid, imm_q, result_q, take_b_q, exp_v, exp_imm_q, exp_result_q, exp_take_q);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_register_stage();
        test_random(400);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
